gf180mcu_fd_io__asig_bank_ctrl: RTL

Parametrised controller for a bank of NCH 5 V analog signal pads sharing one internal analog bus. It accepts channel-select requests over a REQ/ACK handshake, opens all pad switches for a programmable break-before-make dead time, closes the selected switch, waits a settle time, then flags READY. It sits in the digital core domain next to the analog pad ring and drives the per-pad switch enables.

---
 rtl/gf180mcu_fd_io__asig_bank_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/gf180mcu_fd_io__asig_bank_ctrl.sv
// Analog pad bank switch controller: break-before-make channel select with settle timing.
// Latency: REQ accept edge to READY is BBM_CYC+SETTLE_CYC+1 edges; all outputs registered.
// Backpressure: REQ is ignored while BUSY; requester holds REQ until ACK. Option: ASIG_BANK_ISOLATE_EN adds ISO.
module gf180mcu_fd_io__asig_bank_ctrl #(
    parameter int NCH        = 4,
    parameter int BBM_CYC    = 3,
    parameter int SETTLE_CYC = 8,
    localparam int SW        = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [SW-1:0]  SEL,
    input  logic           REQ,
    input  logic           DIS,
    output logic           ACK,
    output logic           ERR,
    output logic           BUSY,
    output logic           READY,
    output logic [NCH-1:0] EN_SW,
    output logic [SW-1:0]  CUR
`ifdef ASIG_BANK_ISOLATE_EN
    ,
    output logic [NCH-1:0] ISO
`endif
);

    localparam int MAXC = (BBM_CYC > SETTLE_CYC) ? BBM_CYC : SETTLE_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] BBM_LD    = CW'(BBM_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [SW:0]   NCH_V     = NCH[SW:0];

    typedef enum logic [1:0] {
        S_OFF,
        S_BREAK,
        S_SETTLE,
        S_ON
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   tgt_q, tgt_d;
    logic [SW-1:0]   cur_d;
    logic            ack_d, err_d, busy_d, ready_d;
    logic [NCH-1:0]  en_d;
    logic            sel_valid;

    assign sel_valid = ({1'b0, SEL} < NCH_V);

    // Next-state, counter and next-output decode; outputs are derived from the next state
    // so that every output flop changes on the same edge as the state it reflects.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_OFF: begin
                if (REQ) begin
                    if (sel_valid) begin
                        tgt_d   = SEL;
                        ack_d   = 1'b1;
                        state_d = S_BREAK;
                        cnt_d   = BBM_LD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (cnt_q == '0) begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_ON;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ON: begin
                if (REQ) begin
                    if (sel_valid) begin
                        ack_d = 1'b1;
                        // Re-selecting the live channel keeps the switch closed untouched.
                        if (SEL != tgt_q) begin
                            tgt_d   = SEL;
                            state_d = S_BREAK;
                            cnt_d   = BBM_LD;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
        endcase

        // Disconnect wins over any request in the same cycle.
        if (DIS) begin
            state_d = S_OFF;
            cnt_d   = '0;
            ack_d   = 1'b0;
            err_d   = 1'b0;
        end

        busy_d  = (state_d == S_BREAK) || (state_d == S_SETTLE);
        ready_d = (state_d == S_ON);
        cur_d   = (state_d == S_ON) ? tgt_d : CUR;
        en_d    = '0;
        for (int i = 0; i < NCH; i++) begin
            en_d[i] = ((state_d == S_SETTLE) || (state_d == S_ON)) && (tgt_d == SW'(i));
        end
    end

    // State, counter, target and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            tgt_q   <= '0;
            ACK     <= 1'b0;
            ERR     <= 1'b0;
            BUSY    <= 1'b0;
            READY   <= 1'b0;
            EN_SW   <= '0;
            CUR     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            ACK     <= ack_d;
            ERR     <= err_d;
            BUSY    <= busy_d;
            READY   <= ready_d;
            EN_SW   <= en_d;
            CUR     <= cur_d;
        end
    end

`ifdef ASIG_BANK_ISOLATE_EN
    // Clamp every pad except the one whose switch is closed; tracks EN_SW edge for edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ISO <= '1;
        end else begin
            ISO <= ~en_d;
        end
    end
`endif

endmodule
